fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction-fetch queue between instruction memory and the ID stage; the successor to the single-entry IF/ID register.
//   Buffers DEPTH fetched {PC, instruction} entries with valid/ready handshakes on both sides, flushes on taken branch/jump, and emits a NOP when empty.
//   Lets fetch run ahead of ID stalls; flush replaces IF/ID aclr, pop_ready replaces IF/ID ldin.
// PARAMETERS
//   DATA_W  32  instruction width in bits
//   PC_W    32  PC width in bits
//   DEPTH   4   number of entries; power of two, >= 2
//   CNT_W   $clog2(DEPTH)+1  occupancy counter width (derived, not overridden)
// PORTS
//   clk           in   1       clock, all state updates on posedge
//   rst           in   1       asynchronous, active-low reset (asserted when 0)
//   flush         in   1       discard all entries (taken branch/jump)
//   push_valid    in   1       fetch side offers an entry
//   push_ready    out  1       queue accepts the entry this cycle
//   push_pc       in   PC_W    PC of the fetched instruction
//   push_instr    in   DATA_W  fetched instruction
//   pop_valid     out  1       head entry available to ID
//   pop_ready     in   1       ID consumes the head this cycle
//   pop_pc        out  PC_W    PC of the head entry
//   pop_pc_plus4  out  PC_W    pop_pc + 4
//   pop_instr     out  DATA_W  head instruction; NOP when pop_valid=0
//   count         out  CNT_W   current occupancy, 0..DEPTH
//   full          out  1       count == DEPTH
//   empty         out  1       count == 0
// BEHAVIOUR
//   - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, so empty=1, full=0, pop_valid=0, pop_instr=NOP (32'h0), pop_pc=0, pop_pc_plus4=4.
//   - Storage contents are not cleared by reset; outputs are masked while empty.
//   - push fire = push_valid & push_ready; pop fire = pop_valid & pop_ready.
//   - push_ready = ~full & ~flush; pop_valid = ~empty & ~flush (combinational from registered state + flush).
//   - Push fire: entry written at wr_ptr on posedge, wr_ptr+1 mod DEPTH, visible at head one cycle later (latency 1).
//   - Pop fire: rd_ptr+1 mod DEPTH on posedge; head data is async read of entry at rd_ptr.
//   - Simultaneous push and pop fire: count unchanged; both pointers advance.
//   - Full: push_ready=0, even if pop_ready=1 the same cycle (no pass-through on full).
//   - Empty: pop_valid=0, pop_instr=NOP, pop_pc=0; pop_ready is ignored.
//   - Pointers wrap from DEPTH-1 to 0; count never exceeds DEPTH or goes below 0.
//   - flush=1: push and pop are both blocked that cycle; on the next posedge wr_ptr=rd_ptr=0 and count=0. Flush overrides everything except reset.
//   - Reset mid-operation: all in-flight entries are lost; the state after deassertion equals the reset state.
//   - pop_pc_plus4 = pop_pc + 4, truncated to PC_W (wraps mod 2^PC_W); forced to 4 when empty.
// CONFIGURATION
//   FETCH_QUEUE_BYPASS_EN defined:
//     - When empty, ~flush and push_valid=1: pop_valid=1 and pop_pc/pop_instr = push_pc/push_instr combinationally (0 latency).
//     - If pop_ready=1 in that same cycle, the entry is not written and count stays 0.
//     - push_ready is unchanged.
//   FETCH_QUEUE_BYPASS_EN undefined: an empty queue always adds 1 cycle of latency, as described above.
// STRUCTURE
//   - Shared package mips_pkg: NOP_INSTR constant (32'h0), PC_INCR constant (4), typedef fq_entry_t {pc, instr}.
//   - One sub-module, fetch_queue_ram: DEPTH x fq_entry_t array, one sync write port and one async read port.
//   - Pointers, counter and handshake logic stay in fetch_queue.
// TESTING
//   1 Reset: rst=0 mid-run with 3 entries -> count=0, empty=1, pop_valid=0, pop_instr=0, pop_pc_plus4=4.
//   2 Fill: DEPTH=4, push PCs 0x00,0x04,0x08,0x0C with pop_ready=0 -> full=1, push_ready=0; a fifth push is rejected.
//     Then drain with pop_ready=1 -> pops in order 0x00..0x0C, pop_pc_plus4 = 0x04..0x10.
//   3 Concurrent: count=2, push and pop fire for 6 cycles -> count stays 2, pointers wrap, order preserved.
//   4 Flush: count=3, flush=1 with push_valid=1 -> push_ready=0, pop_valid=0; next cycle count=0.
//     The post-flush push of PC 0x40 is the first pop.
//   5 Wrap arithmetic: push_pc=32'hFFFF_FFFC -> pop_pc_plus4=32'h0000_0000.
//   6 Bypass (macro defined): empty queue, push 0x20 with pop_ready=1 -> pop_valid=1 in the same cycle, pop_pc=0x20, count stays 0.
//     Without the macro, the same stimulus gives pop_valid=0 this cycle and pop_valid=1 the next.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Encoding of the no-operation instruction (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sequential PC step between instructions.
  localparam logic [31:0] PC_INCR = 32'd4;

  // One fetched entry at the default 32-bit PC/instruction widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_ram.sv
// ============================================================================
// Module      : fetch_queue_ram
// Description : DEPTH-entry {pc, instr} storage, one synchronous write port
//               and one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_ram #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PC_W-1:0]   wpc,
  input  logic [DATA_W-1:0] winstr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PC_W-1:0]   rpc,
  output logic [DATA_W-1:0] rinstr
);

  // Same layout as mips_pkg::fq_entry_t, sized by this instance's widths.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t mem [DEPTH];

  // Write the offered entry at the write address on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= '{pc: wpc, instr: winstr};
    end
  end

  assign rpc    = mem[raddr].pc;
  assign rinstr = mem[raddr].instr;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch queue between instruction memory and ID.
//               Buffers DEPTH {pc, instr} entries with valid/ready on both
//               sides, flushes on taken branch/jump, emits NOP when empty.
//               Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards
//               the incoming entry to the head combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [DATA_W-1:0] push_instr,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [PC_W-1:0]   pop_pc,
  output logic [PC_W-1:0]   pop_pc_plus4,
  output logic [DATA_W-1:0] pop_instr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic [PC_W-1:0]   ram_pc;
  logic [DATA_W-1:0] ram_instr;
  logic              stored_valid;
  logic              bypass;
  logic              wr_en;
  logic              rd_en;
  logic [PC_W-1:0]   head_pc;
  logic [DATA_W-1:0] head_instr;

  assign full  = (occ == CNT_W'(DEPTH));
  assign empty = (occ == '0);
  assign count = occ;

  // Handshakes are blocked entirely during a flush; no pass-through on full.
  assign push_ready   = ~full & ~flush;
  assign stored_valid = ~empty & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: present the incoming entry at the head in the same cycle.
  assign bypass = empty & ~flush & push_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop_valid = stored_valid | bypass;

  // A bypassed entry consumed this cycle is never stored.
  assign wr_en = push_valid & push_ready & ~(bypass & pop_ready);
  // Only stored entries advance the read side.
  assign rd_en = stored_valid & pop_ready;

  // Select the head source and mask it to NOP/PC 0 whenever nothing is valid.
  always_comb begin
    head_pc    = '0;
    head_instr = DATA_W'(NOP_INSTR);
    if (bypass) begin
      head_pc    = push_pc;
      head_instr = push_instr;
    end else if (stored_valid) begin
      head_pc    = ram_pc;
      head_instr = ram_instr;
    end
  end

  assign pop_pc       = head_pc;
  assign pop_instr    = head_instr;
  assign pop_pc_plus4 = head_pc + PC_W'(PC_INCR);

  // Pointer and occupancy update; flush empties the queue, reset wins over all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        occ <= occ + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        occ <= occ - CNT_W'(1);
      end
    end
  end

  fetch_queue_ram #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .waddr  (wr_ptr),
    .wpc    (push_pc),
    .winstr (push_instr),
    .raddr  (rd_ptr),
    .rpc    (ram_pc),
    .rinstr (ram_instr)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue (DEPTH=4) against a
//               queue-based reference model; honours FETCH_QUEUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_pc = '0;
  logic [31:0] push_instr = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_pc;
  logic [31:0] pop_pc_plus4;
  logic [31:0] pop_instr;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the queue, oldest first.
  logic [31:0] m_pc[$];
  logic [31:0] m_ins[$];

  fetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_pc      (push_pc),
    .push_instr   (push_instr),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .pop_pc       (pop_pc),
    .pop_pc_plus4 (pop_pc_plus4),
    .pop_instr    (pop_instr),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Drive one cycle's inputs (called just after a rising edge).
  task automatic drive(input logic pv, input logic pr, input logic fl, input logic [31:0] pc);
    push_valid = pv;
    pop_ready  = pr;
    flush      = fl;
    push_pc    = pc;
    push_instr = instr_of(pc);
    #1;
  endtask

  // Compare all outputs against the model at the falling edge, then advance
  // the model on the rising edge.
  task automatic tick();
    int  sz;
    bit  e_empty, e_full, e_pr, e_byp, e_pv, do_push, do_pop;
    logic [31:0] e_pc, e_ins;
    @(negedge clk);
    sz      = m_pc.size();
    e_empty = (sz == 0);
    e_full  = (sz == DEPTH);
    e_pr    = !e_full && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    e_byp   = e_empty && !flush && push_valid;
`else
    e_byp   = 1'b0;
`endif
    e_pv    = (!e_empty && !flush) || e_byp;
    e_pc    = 32'h0;
    e_ins   = 32'h0;
    if (e_byp) begin
      e_pc  = push_pc;
      e_ins = push_instr;
    end else if (e_pv) begin
      e_pc  = m_pc[0];
      e_ins = m_ins[0];
    end
    chk("count",        32'(count),        32'(sz));
    chk("empty",        32'(empty),        32'(e_empty));
    chk("full",         32'(full),         32'(e_full));
    chk("push_ready",   32'(push_ready),   32'(e_pr));
    chk("pop_valid",    32'(pop_valid),    32'(e_pv));
    chk("pop_pc",       pop_pc,            e_pc);
    chk("pop_instr",    pop_instr,         e_ins);
    chk("pop_pc_plus4", pop_pc_plus4,      e_pc + 32'd4);
    do_push = push_valid && e_pr;
    do_pop  = e_pv && pop_ready;
    @(posedge clk);
    if (flush) begin
      m_pc.delete();
      m_ins.delete();
    end else if (!(e_byp && do_pop)) begin
      if (do_pop) begin
        void'(m_pc.pop_front());
        void'(m_ins.pop_front());
      end
      if (do_push) begin
        m_pc.push_back(push_pc);
        m_ins.push_back(push_instr);
      end
    end
    #1;
  endtask

  task automatic cyc(input logic pv, input logic pr, input logic fl, input logic [31:0] pc);
    drive(pv, pr, fl, pc);
    tick();
  endtask

  initial begin
    // ---------------- reset state ----------------
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",  32'(count),   32'd0);
    chk("rst_empty",  32'(empty),   32'd1);
    chk("rst_pv",     32'(pop_valid), 32'd0);
    chk("rst_instr",  pop_instr,    32'h0);
    chk("rst_plus4",  pop_plus4_w(), 32'd4);
    rst = 1'b1;
    #1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // ---------------- fill ----------------
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i * 4));
    drive(1'b1, 1'b0, 1'b0, 32'h10);
    chk("fill_full",  32'(full),       32'd1);
    chk("fill_pr",    32'(push_ready), 32'd0);
    tick();
    chk("fill_cnt5",  32'(count),      32'd4);
    // ---------------- drain ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      chk("drain_pc",    pop_pc,       32'(i * 4));
      chk("drain_plus4", pop_pc_plus4, 32'(i * 4 + 4));
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // ---------------- concurrent ----------------
    cyc(1'b1, 1'b0, 1'b0, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 32'h104);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(32'h108 + i * 4));
      chk("conc_pc", pop_pc, 32'(32'h100 + i * 4));
      tick();
      chk("conc_cnt", 32'(count), 32'd2);
    end

    // ---------------- flush ----------------
    cyc(1'b1, 1'b0, 1'b0, 32'h200);
    chk("fl_cnt3", 32'(count), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 32'h204);
    chk("fl_pr", 32'(push_ready), 32'd0);
    chk("fl_pv", 32'(pop_valid),  32'd0);
    tick();
    chk("fl_cnt0", 32'(count), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h40);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fl_first", pop_pc, 32'h40);
    tick();

    // ---------------- PC wrap ----------------
    cyc(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc",    pop_pc,       32'hFFFF_FFFC);
    chk("wrap_plus4", pop_pc_plus4, 32'h0000_0000);
    tick();

    // ---------------- bypass / latency ----------------
    drive(1'b1, 1'b1, 1'b0, 32'h20);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_pv", 32'(pop_valid), 32'd1);
    chk("byp_pc", pop_pc,         32'h20);
    tick();
    chk("byp_cnt", 32'(count), 32'd0);
`else
    chk("nobyp_pv0", 32'(pop_valid), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("nobyp_pv1", 32'(pop_valid), 32'd1);
    chk("nobyp_pc",  pop_pc,         32'h20);
    tick();
`endif

    // ---------------- reset mid-run ----------------
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'(32'h300 + i * 4));
    chk("mr_cnt3", 32'(count), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chk("mr_count", 32'(count),     32'd0);
    chk("mr_empty", 32'(empty),     32'd1);
    chk("mr_pv",    32'(pop_valid), 32'd0);
    chk("mr_instr", pop_instr,      32'h0);
    chk("mr_plus4", pop_pc_plus4,   32'd4);
    m_pc.delete();
    m_ins.delete();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 19) == 0),
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [31:0] pop_plus4_w();
    return pop_pc_plus4;
  endfunction

endmodule

`default_nettype wire
